pipelined_cla_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_group.sv | 47 ++++
 rtl/pipelined_cla_adder.sv | 105 ++++++++++
 tb/tb_pipelined_cla_adder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants, depth helper and stage payload for the pipelined CLA.
// Imported by cla_group and pipelined_cla_adder.
package cla_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLOCK = 4;

  function automatic int nstage(input int width, input int block);
    return width / block;
  endfunction

  // Payload of one pipeline stage at the default width.
  typedef struct packed {
    logic                 v;
    logic                 c;
    logic                 cm;
    logic [DEF_WIDTH-1:0] s;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } stage_t;

endpackage

// File: rtl/cla_group.sv
// Combinational BLOCK-bit carry-look-ahead group.
// Ports: a, b, c in; s, c_out, c_msb_in (carry into group MSB) out.
module cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             c,
  output logic [BLOCK-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   cy;
  logic             acc;
  logic             pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat sum-of-products
  // g[i] | p[i]g[i-1] | ... | p[i..0]c.
  always_comb begin
    cy    = '0;
    acc   = 1'b0;
    pp    = 1'b0;
    cy[0] = c;
    for (int i = 0; i < BLOCK; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      cy[i+1] = acc | (pp & c);
    end
  end

  assign s        = p ^ cy[BLOCK-1:0];
  assign c_out    = cy[BLOCK];
  assign c_msb_in = cy[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor, one BLOCK-bit group per stage.
// Ports: clk, rst_n, in_valid/in_ready, a, b, cin, sub,
//        out_valid/out_ready, s, cout, ovf.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int BLOCK  = DEF_BLOCK,
  localparam int NSTAGE = nstage(WIDTH, BLOCK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  if (WIDTH % BLOCK != 0) begin : g_chk
    $error("WIDTH must be a multiple of BLOCK");
  end

  typedef struct packed {
    logic             v;
    logic             c;
    logic             cm;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } lane_t;

  lane_t head;
  logic  adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    head   = '0;
    head.v = in_valid;
    head.c = cin ^ sub;
    head.a = a;
    head.b = sub ? ~b : b;
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_st
    lane_t            cur;
    lane_t            nx;
    lane_t            r;
    logic [BLOCK-1:0] gs;
    logic             gc;
    logic             gm;

    if (k == 0) begin : g_in
      assign cur = head;
    end else begin : g_mid
      assign cur = g_st[k-1].r;
    end

    cla_group #(
      .BLOCK(BLOCK)
    ) u_grp (
      .a       (cur.a[k*BLOCK +: BLOCK]),
      .b       (cur.b[k*BLOCK +: BLOCK]),
      .c       (cur.c),
      .s       (gs),
      .c_out   (gc),
      .c_msb_in(gm)
    );

    always_comb begin
      nx                     = cur;
      nx.s[k*BLOCK +: BLOCK] = gs;
      nx.c                   = gc;
      nx.cm                  = gm;
    end

    // Bubbles only clear the valid bit so the last
    // result stays on s/cout/ovf.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r <= '0;
      end else if (adv) begin
        if (cur.v) begin
          r <= nx;
        end else begin
          r.v <= 1'b0;
        end
      end
    end
  end

  assign out_valid = g_st[NSTAGE-1].r.v;
  assign s         = g_st[NSTAGE-1].r.s;
  assign cout      = g_st[NSTAGE-1].r.c;
  assign ovf       = g_st[NSTAGE-1].r.c ^ g_st[NSTAGE-1].r.cm;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (16/4 and 4/4).
// Arithmetic reference model plus directed vectors.
module tb_pipelined_cla_adder;

  localparam int W  = 16;
  localparam int B  = 4;
  localparam int NS = W / B;

  typedef struct packed {
    logic         c;
    logic         o;
    logic [W-1:0] s;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  logic       iv4;
  logic       ir4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       cin4;
  logic       sub4;
  logic       ov4;
  logic       or4;
  logic [3:0] s4;
  logic       cout4;
  logic       ovf4;

  int checks = 0;
  int errors = 0;

  res_t q[$];

  always #5 clk = ~clk;

  pipelined_cla_adder #(
    .WIDTH(W),
    .BLOCK(B)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .cout     (cout),
    .ovf      (ovf)
  );

  pipelined_cla_adder #(
    .WIDTH(4),
    .BLOCK(4)
  ) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (iv4),
    .in_ready (ir4),
    .a        (a4),
    .b        (b4),
    .cin      (cin4),
    .sub      (sub4),
    .out_valid(ov4),
    .out_ready(or4),
    .s        (s4),
    .cout     (cout4),
    .ovf      (ovf4)
  );

  function automatic res_t model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         ci,
    input logic         sb
  );
    logic [W-1:0] ye;
    logic [W:0]   tot;
    longint       ss;
    longint       smax;
    res_t         r;
    ye   = sb ? ~y : y;
    tot  = {1'b0, x} + {1'b0, ye} + (W+1)'(ci ^ sb);
    ss   = longint'($signed(x)) + longint'($signed(ye))
         + longint'(ci ^ sb);
    smax = (longint'(1) <<< (W - 1)) - 1;
    r.c  = tot[W];
    r.s  = tot[W-1:0];
    r.o  = (ss > smax) || (ss < -smax - 1);
    return r;
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: sampled after stimulus settles, before the next edge.
  logic pstall = 1'b0;
  res_t pres;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        q.delete();
        pstall = 1'b0;
      end else begin
        if (pstall) begin
          check("stall_hold", {out_valid, cout, ovf, s},
                {1'b1, pres});
        end
        if (out_valid && out_ready) begin
          check("result_present", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            check("result", {cout, ovf, s}, q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(model(a, b, cin, sub));
        end
        pstall = out_valid && !out_ready;
        pres   = {cout, ovf, s};
      end
    end
  end

  task automatic send(input logic [W-1:0] x,
                      input logic [W-1:0] y,
                      input logic         ci,
                      input logic         sb);
    int t;
    @(negedge clk);
    a        = x;
    b        = y;
    cin      = ci;
    sub      = sb;
    in_valid = 1'b1;
    #1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 200) check("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      t++;
    end
    check("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    iv4       = 1'b0;
    a4        = '0;
    b4        = '0;
    cin4      = 1'b0;
    sub4      = 1'b0;
    or4       = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_s", s, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst4_out_valid", ov4, 1'b0);

    // Hand-computed values pin the reference model.
    check("pin_ffff", model(16'hFFFF, 16'h0001, 0, 0),
          {1'b1, 1'b0, 16'h0000});
    check("pin_7fff", model(16'h7FFF, 16'h0001, 0, 0),
          {1'b0, 1'b1, 16'h8000});
    check("pin_5m7", model(16'h0005, 16'h0007, 0, 1),
          {1'b0, 1'b0, 16'hFFFE});
    check("pin_8000m1", model(16'h8000, 16'h0001, 0, 1),
          {1'b1, 1'b1, 16'h7FFF});
    check("pin_5m7m1", model(16'h0005, 16'h0007, 1, 1),
          {1'b0, 1'b0, 16'hFFFD});

    @(negedge clk);
    rst_n = 1'b1;

    // 4-bit single-stage instance.
    @(negedge clk);
    a4   = 4'b1010;
    b4   = 4'b1011;
    cin4 = 1'b1;
    iv4  = 1'b1;
    @(negedge clk);
    a4   = 4'b0010;
    b4   = 4'b0101;
    cin4 = 1'b1;
    #1;
    check("w4_v1", {ov4, cout4, ovf4, s4},
          {1'b1, 1'b1, 1'b1, 4'b0110});
    @(negedge clk);
    iv4 = 1'b0;
    #1;
    check("w4_v2", {ov4, cout4, ovf4, s4},
          {1'b1, 1'b0, 1'b1, 4'b1000});
    @(negedge clk);
    #1;
    check("w4_bubble", {ov4, cout4, ovf4, s4},
          {1'b0, 1'b0, 1'b1, 4'b1000});

    // Latency of a lone beat.
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    for (int i = 1; i <= NS + 1; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("latency", out_valid, 64'(i == NS));
    end
    check("lone_s", {cout, ovf, s}, {1'b0, 1'b0, 16'h5555});

    // Back-to-back directed beats, results on consecutive cycles.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    for (int k = 1; k <= NS + 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("b2b_valid", out_valid, 64'(k >= NS - 3 && k <= NS));
    end
    drain();

    // Back-pressure.
    out_ready = 1'b0;
    for (int i = 0; i < NS; i++) begin
      send(16'h1000 + 16'(i), 16'h00F0, 1'b1, 1'(i & 1));
    end
    @(negedge clk);
    a        = 16'hAAAA;
    b        = 16'h5555;
    cin      = 1'b1;
    sub      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Reset with three beats in flight.
    send(16'h0101, 16'h0202, 1'b0, 1'b0);
    send(16'h0303, 16'h0404, 1'b0, 1'b0);
    send(16'h0505, 16'h0606, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst", {out_valid, cout, ovf, s}, 19'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("midrst_quiet", out_valid, 1'b0);
    end

    // Random traffic against the model.
    acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!in_valid || acc) begin
        in_valid = ($urandom % 4) != 0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        sub      = 1'($urandom);
      end
      out_ready = ($urandom % 4) != 0;
      #1;
      acc = in_valid && in_ready;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
